// File: rtl/core101_mem_pkg.sv
// Shared encodings for the core-to-data-memory interface: FSM states, access sizes,
// opcode bit layout and RISC-V load/store funct3 values.
package core101_mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StResp = 2'b10,
        StErr  = 2'b11
    } lsu_state_e;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Opcode is {store, size[1:0]}
    localparam int unsigned OPC_STORE_BIT = 2;
    localparam int unsigned OPC_SIZE_HI   = 1;
    localparam int unsigned OPC_SIZE_LO   = 0;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW: return 1'b1;
            F3_LBU, F3_LHU:      return !store;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_H:  return !addr_lo[0];
            SIZE_W:  return addr_lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: picks the addressed byte/half from an aligned word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import core101_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [2:0]            funct3_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_sel = word_i[7:0];
            2'b01:   byte_sel = word_i[15:8];
            2'b10:   byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            F3_LB:   data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LH:   data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access, checks legality and alignment, issues a
// valid/ready data memory request with timeout, and returns load data or status.
module load_store_unit
    import core101_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  lsu_valid_in,
    output logic                  lsu_ready_out,
    input  logic                  lsu_store_in,
    input  logic [2:0]            lsu_funct3_in,
    input  logic [DATA_WIDTH-1:0] lsu_addr_in,
    input  logic [DATA_WIDTH-1:0] lsu_data_in,
    output logic                  lsu_done_out,
    output logic [DATA_WIDTH-1:0] lsu_data_out,
    output logic                  lsu_error_out,
    output logic                  data_mem_valid_out,
    output logic [2:0]            data_mem_opcode_out,
    output logic [DATA_WIDTH-1:0] data_mem_addr_out,
    output logic [DATA_WIDTH-1:0] data_mem_data_out,
    input  logic                  data_mem_ready_in,
    input  logic [DATA_WIDTH-1:0] data_mem_data_in
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    lsu_state_e            state_q;
    logic                  store_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  valid_q;
    logic                  ready_q;
    logic                  done_q;
    logic                  error_q;

    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [DATA_WIDTH-1:0] load_aligned;
    logic                  req_ok;

    // Memory sees the store data replicated into every lane of its size.
    always_comb begin
        case (lsu_funct3_in[1:0])
            SIZE_B:  wdata_rep = {(DATA_WIDTH/8){lsu_data_in[7:0]}};
            SIZE_H:  wdata_rep = {(DATA_WIDTH/16){lsu_data_in[15:0]}};
            default: wdata_rep = lsu_data_in;
        endcase
        req_ok = funct3_legal(lsu_store_in, lsu_funct3_in)
               && addr_aligned(lsu_funct3_in[1:0], lsu_addr_in[1:0]);
    end

    lsu_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .word_i   (data_mem_data_in),
        .addr_lo_i(addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (load_aligned)
    );

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= StIdle;
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (lsu_valid_in) begin
                        store_q  <= lsu_store_in;
                        funct3_q <= lsu_funct3_in;
                        addr_q   <= lsu_addr_in;
                        wdata_q  <= wdata_rep;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        if (req_ok) begin
                            state_q <= StReq;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= StErr;
                            error_q <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    // Ready takes priority over a coincident timeout.
                    if (data_mem_ready_in) begin
                        state_q <= StResp;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        rdata_q <= store_q ? '0 : load_aligned;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= StErr;
                        valid_q <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    rdata_q <= '0;
                    ready_q <= 1'b1;
                end
                StErr: begin
                    state_q <= StIdle;
                    error_q <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        data_mem_opcode_out = '0;
        if (valid_q) begin
            data_mem_opcode_out[OPC_STORE_BIT]           = store_q;
            data_mem_opcode_out[OPC_SIZE_HI:OPC_SIZE_LO] = funct3_q[1:0];
        end
    end

    assign data_mem_valid_out = valid_q;
    assign data_mem_addr_out  = valid_q ? addr_q : '0;
    assign data_mem_data_out  = valid_q ? wdata_q : '0;
    assign lsu_ready_out      = ready_q;
    assign lsu_done_out       = done_q;
    assign lsu_error_out      = error_q;
    assign lsu_data_out       = rdata_q;

endmodule
